counter8_seq: RTL

//   Sequencer for the loadable 8-bit counter built from two cascaded LS163 slices.

---
 rtl/counter8_seq_if.sv | 30 +++
 rtl/counter8_seq.sv | 90 +++++++++
 2 files changed

// File: rtl/counter8_seq_if.sv
// Host and counter-pin bundle for the LS163 timer sequencer.
// The slave side is the sequencer; the master side is the host plus counter pair.
interface counter8_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             START;
  logic             MODE;
  logic [WIDTH-1:0] LEN;
  logic             STOP;
  logic             HOLD;
  logic [WIDTH-1:0] Q;
  logic             nCLR;
  logic             nLOAD;
  logic [WIDTH-1:0] Din;
  logic             ENP;
  logic             ENT;
  logic             BUSY;
  logic             TICK;
  logic             DONE;

  modport master (
    output START, MODE, LEN, STOP, HOLD, Q,
    input  nCLR, nLOAD, Din, ENP, ENT, BUSY, TICK, DONE
  );

  modport slave (
    input  START, MODE, LEN, STOP, HOLD, Q,
    output nCLR, nLOAD, Din, ENP, ENT, BUSY, TICK, DONE
  );
endinterface

// File: rtl/counter8_seq.sv
// Sequencer for a loadable counter built from cascaded LS163 slices, forming a
// one-shot or periodic timer with start/stop/hold control.
module counter8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic            CLK,
  input logic            RST,
  counter8_seq_if.slave  bus
);

  typedef enum logic [1:0] {StClr, StIdle, StLoad, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] din_q;
  logic             mode_q;
  logic             done_q;

  logic q_full;
  logic term;
  logic n_clr, n_load, enp, ent, busy, tick;

  // Terminal count is decoded from Q directly; the slices' RCO is not used.
  assign q_full = (bus.Q == {WIDTH{1'b1}});
  assign term   = (state_q == StRun) & q_full & ~bus.HOLD & ~bus.STOP;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StClr;
      din_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= term & ~mode_q;
      unique case (state_q)
        StClr:  state_q <= StIdle;
        StIdle: begin
          if (bus.START) begin
            mode_q  <= bus.MODE;
            // Counting up from -LEN reaches all-ones after LEN-1 increments.
            din_q   <= (~bus.LEN) + WIDTH'(1);
            state_q <= StLoad;
          end
        end
        StLoad: state_q <= StRun;
        StRun: begin
          if (bus.STOP || (term && !mode_q)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StClr;
      endcase
    end
  end

  always_comb begin
    n_clr  = 1'b1;
    n_load = 1'b1;
    enp    = 1'b0;
    ent    = 1'b0;
    busy   = 1'b0;
    tick   = 1'b0;
    unique case (state_q)
      StClr:  n_clr = 1'b0;
      StIdle: ;
      StLoad: begin
        n_load = 1'b0;
        busy   = 1'b1;
      end
      StRun: begin
        busy   = 1'b1;
        ent    = ~bus.STOP;
        // A finished one-shot parks the counter at all-ones.
        enp    = ~bus.HOLD & ~bus.STOP & ~(term & ~mode_q);
        tick   = term;
        n_load = ~(term & mode_q);
      end
      default: ;
    endcase
  end

  assign bus.nCLR  = n_clr;
  assign bus.nLOAD = n_load;
  assign bus.Din   = din_q;
  assign bus.ENP   = enp;
  assign bus.ENT   = ent;
  assign bus.BUSY  = busy;
  assign bus.TICK  = tick;
  assign bus.DONE  = done_q;

endmodule
